bcd_pulse_gen: RTL and testbench
================================

BCD_PULSE_GEN -- requirements
Module: bcd_pulse_gen

Interface
REQ-001 The block SHALL have exactly one clock and one reset: the clock is CLK, and the reset is RESET, synchronous and active-high.
REQ-002 CLK  input  1  rising-edge clock for all state.
REQ-003 RESET  input  1  synchronous active-high reset, sampled on rising CLK.
REQ-004 START  input  1  single-cycle request to validate and latch PRESET, then begin counting.
REQ-005 STOP  input  1  abort request; returns the block to idle.
REQ-006 MODE  input  1  sampled with an accepted START: 0 = one-shot, 1 = continuous.
REQ-007 EN  input  1  count enable; each RUN cycle with EN=1 is one count.
REQ-008 PRESET  input  12  three BCD digits: [11:8] hundreds, [7:4] tens, [3:0] units.
REQ-009 PULSE  output  1  registered one-cycle terminal-count pulse.
REQ-010 BUSY  output  1  high while in RUN.
REQ-011 ERR  output  1  sticky flag for a rejected START.
REQ-012 Q  output  12  remaining count in BCD, same digit layout as PRESET.

Function
REQ-013 The block SHALL have two states, IDLE and RUN; BUSY=1 exactly when in RUN.
REQ-014 In IDLE, Q SHALL be 000 and PULSE SHALL be 0.
REQ-015 A START accepted in IDLE SHALL latch PRESET and MODE into internal registers.
  - Validity: PRESET is valid when every digit is at most 9 and the value is not 000.
  - Same edge: Q<=PRESET, ERR<=0, state<=RUN.
REQ-016 A START in IDLE with an invalid PRESET SHALL set ERR=1 and leave the block in IDLE with Q=000.
REQ-017 ERR SHALL hold until the next accepted valid START or RESET.
REQ-018 START while in RUN SHALL be ignored; PRESET and MODE changes during RUN SHALL have no effect.
REQ-019 In RUN with EN=0, Q SHALL hold.
REQ-020 In RUN with EN=1 and Q not equal to 001, Q SHALL decrement by one in BCD.
  - Units 0 becomes 9 and borrows from tens; tens 0 becomes 9 and borrows from hundreds.
  - Examples: 100->099, 010->009, 001 is the terminal value.
REQ-021 In RUN with EN=1 and Q=001, the block SHALL set PULSE=1 for exactly the following cycle.
  - Continuous mode: Q<=latched PRESET and the block stays in RUN.
  - One-shot mode: Q<=000 and state<=IDLE.
REQ-022 The pulse period SHALL be exactly N enabled cycles, where N is the latched PRESET value.
  - An accepted START at edge k gives the first PULSE after the k+N edge when EN is held at 1.
  - Continuous mode: subsequent PULSEs follow every N enabled cycles with no gap cycle.
  - PRESET=001 in continuous mode with EN=1 gives PULSE=1 on every cycle.
REQ-023 STOP SHALL take priority over START, EN and the terminal count.
  - Effect: state<=IDLE, Q<=000, PULSE<=0, with ERR unchanged.
  - A terminal count coincident with STOP SHALL produce no PULSE.
REQ-024 STOP and START in the same IDLE cycle SHALL leave the block in IDLE with no change to ERR.
REQ-025 Q SHALL never hold a non-BCD digit; decrement logic SHALL be per-digit 4-bit with explicit borrow and no binary wrap.

Reset
REQ-026 RESET=1 at a rising CLK edge SHALL force IDLE, Q=000, PULSE=0, BUSY=0, ERR=0, and clear the latched PRESET and MODE to 0.
REQ-027 RESET SHALL override STOP, START and EN, including mid-RUN; there SHALL be no PULSE on the reset cycle or the cycle after it.
REQ-028 Behaviour after RESET deasserts SHALL be identical to power-on IDLE.

Verification
REQ-029 Continuous count: PRESET=003, MODE=1, EN=1, START one cycle.
  - Response: Q sequence 003,002,001,003,...
  - Response: PULSE high one cycle every 3 cycles, first at edge k+3; BUSY=1 throughout.
REQ-030 Digit borrow: PRESET=100, MODE=0, EN=1.
  - Response: Q passes 100->099->...->010->009->...->001->000.
  - Response: a single PULSE after 100 enabled cycles, then BUSY=0.
REQ-031 Invalid presets: START with PRESET=0A5, then START with PRESET=000.
  - Response: ERR=1 and BUSY=0 each time.
  - Follow-up: START with PRESET=005 clears ERR and sets BUSY=1.
REQ-032 Enable gaps and ignored inputs: PRESET=004, MODE=1, EN toggling 1,0,1,0,...
  - Response: Q holds on EN=0 cycles and PULSE occurs after 4 enabled cycles.
  - Response: a START and a PRESET change mid-RUN have no effect.
REQ-033 STOP at the terminal count: STOP asserted in the cycle Q=001 with EN=1.
  - Response: no PULSE, Q=000, BUSY=0.
  - Also check: STOP+START together in IDLE leaves IDLE.
REQ-034 Reset mid-RUN: RESET asserted while Q=002, MODE=1.
  - Response: next cycle Q=000, BUSY=0, ERR=0, PULSE=0.
  - Response: a later START with PRESET=002 restarts with a correct period.

Source files
------------

// File: rtl/bcd_pulse_gen.sv
// rtl/bcd_pulse_gen.sv - three-digit BCD down-counter emitting a terminal-count pulse
// Counts enabled cycles from a latched preset; one-shot or continuous reload.
module bcd_pulse_gen (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    input  logic        STOP,
    input  logic        MODE,
    input  logic        EN,
    input  logic [11:0] PRESET,
    output logic        PULSE,
    output logic        BUSY,
    output logic        ERR,
    output logic [11:0] Q
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [11:0] r_q;
    logic [11:0] r_preset;
    logic        r_mode;
    logic        r_pulse;
    logic        r_err;

    logic        w_preset_valid;
    logic        w_accept;
    logic        w_reject;
    logic        w_terminal;
    logic [3:0]  w_units;
    logic [3:0]  w_tens;
    logic [3:0]  w_hund;
    logic        w_borrow_u;
    logic        w_borrow_t;
    logic [11:0] w_q_dec;

    always_comb begin
        w_preset_valid = (PRESET[11:8] <= 4'd9) && (PRESET[7:4] <= 4'd9) &&
                         (PRESET[3:0] <= 4'd9) && (PRESET != 12'h000);
        w_accept   = (r_state == S_IDLE) && START && !STOP && w_preset_valid;
        w_reject   = (r_state == S_IDLE) && START && !STOP && !w_preset_valid;
        w_terminal = (r_state == S_RUN) && EN && !STOP && (r_q == 12'h001);
    end

    // Per-digit decrement with explicit borrow so no digit ever leaves 0..9
    always_comb begin
        w_borrow_u = (r_q[3:0] == 4'd0);
        w_units    = w_borrow_u ? 4'd9 : r_q[3:0] - 4'd1;
        w_borrow_t = w_borrow_u && (r_q[7:4] == 4'd0);
        if (!w_borrow_u)
            w_tens = r_q[7:4];
        else if (w_borrow_t)
            w_tens = 4'd9;
        else
            w_tens = r_q[7:4] - 4'd1;
        if (!w_borrow_t)
            w_hund = r_q[11:8];
        else if (r_q[11:8] == 4'd0)
            w_hund = 4'd9;
        else
            w_hund = r_q[11:8] - 4'd1;
        w_q_dec = {w_hund, w_tens, w_units};
    end

    always_ff @(posedge CLK) begin
        if (RESET)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = S_RUN;
            S_RUN: begin
                if (STOP)
                    w_next = S_IDLE;
                else if (w_terminal && !r_mode)
                    w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_q      <= 12'h000;
            r_preset <= 12'h000;
            r_mode   <= 1'b0;
            r_pulse  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_pulse <= w_terminal;
            if (STOP) begin
                r_q <= 12'h000;
            end else if (w_accept) begin
                r_q      <= PRESET;
                r_preset <= PRESET;
                r_mode   <= MODE;
                r_err    <= 1'b0;
            end else if (w_reject) begin
                r_err <= 1'b1;
            end else if (r_state == S_RUN && EN) begin
                if (w_terminal)
                    r_q <= r_mode ? r_preset : 12'h000;
                else
                    r_q <= w_q_dec;
            end
        end
    end

    always_comb begin
        BUSY  = (r_state == S_RUN);
        PULSE = r_pulse;
        ERR   = r_err;
        Q     = r_q;
    end

endmodule

// File: tb/tb_bcd_pulse_gen.sv
// tb/tb_bcd_pulse_gen.sv - vector table, corner sequences and random run against an integer model
module tb_bcd_pulse_gen;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        START = 1'b0;
    logic        STOP = 1'b0;
    logic        MODE = 1'b0;
    logic        EN = 1'b0;
    logic [11:0] PRESET = 12'h000;
    logic        PULSE;
    logic        BUSY;
    logic        ERR;
    logic [11:0] Q;

    int checks = 0;
    int failures = 0;

    bcd_pulse_gen dut (
        .CLK(CLK), .RESET(RESET), .START(START), .STOP(STOP), .MODE(MODE),
        .EN(EN), .PRESET(PRESET), .PULSE(PULSE), .BUSY(BUSY), .ERR(ERR), .Q(Q)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst, start, stop, mode, en;
        logic [11:0] preset;
        logic [11:0] q;
        logic        busy, err, pulse;
    } vec_t;

    vec_t vecs[$];

    // Reference model: remaining count kept as a plain integer
    int m_cnt, m_pre;
    bit m_run, m_err, m_pulse, m_mode;

    function automatic int bcd2int(input logic [11:0] b);
        return int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [11:0] int2bcd(input int n);
        logic [11:0] r;
        r[11:8] = 4'((n / 100) % 10);
        r[7:4]  = 4'((n / 10) % 10);
        r[3:0]  = 4'(n % 10);
        return r;
    endfunction

    function automatic bit is_valid(input logic [11:0] p);
        return p[11:8] < 10 && p[7:4] < 10 && p[3:0] < 10 && p != 12'h000;
    endfunction

    task automatic model_step(input logic rst, st, sp, md, e, input logic [11:0] pr);
        if (rst) begin
            m_cnt = 0; m_pre = 0; m_run = 0; m_err = 0; m_pulse = 0; m_mode = 0;
        end else if (sp) begin
            m_run = 0; m_cnt = 0; m_pulse = 0;
        end else if (!m_run) begin
            m_pulse = 0;
            if (st) begin
                if (is_valid(pr)) begin
                    m_pre = bcd2int(pr); m_mode = md; m_cnt = m_pre; m_err = 0; m_run = 1;
                end else begin
                    m_err = 1;
                end
            end
        end else begin
            m_pulse = 0;
            if (e) begin
                if (m_cnt == 1) begin
                    m_pulse = 1;
                    if (m_mode) m_cnt = m_pre;
                    else begin m_cnt = 0; m_run = 0; end
                end else begin
                    m_cnt = m_cnt - 1;
                end
            end
        end
    endtask

    task automatic step(input logic rst, st, sp, md, e, input logic [11:0] pr);
        RESET = rst; START = st; STOP = sp; MODE = md; EN = e; PRESET = pr;
        @(posedge CLK);
        model_step(rst, st, sp, md, e, pr);
        #1;
    endtask

    task automatic chk(input string nm, input logic [11:0] eq, input logic eb, ee, ep);
        checks++;
        if (Q !== eq || BUSY !== eb || ERR !== ee || PULSE !== ep) begin
            failures++;
            $display("FAIL %s: got Q=%03h BUSY=%b ERR=%b PULSE=%b, expected Q=%03h BUSY=%b ERR=%b PULSE=%b",
                     nm, Q, BUSY, ERR, PULSE, eq, eb, ee, ep);
        end
    endtask

    task automatic chk_model(input string nm);
        chk(nm, int2bcd(m_cnt), m_run, m_err, m_pulse);
    endtask

    function automatic vec_t v(input logic rst, st, sp, md, e, input logic [11:0] pr,
                               input logic [11:0] q, input logic b, er, p);
        vec_t x;
        x.rst = rst; x.start = st; x.stop = sp; x.mode = md; x.en = e; x.preset = pr;
        x.q = q; x.busy = b; x.err = er; x.pulse = p;
        return x;
    endfunction

    initial begin
        int pulses;
        int pulse_at;
        logic [11:0] pr;

        //                rst st sp md en preset     q    busy err pulse
        vecs.push_back(v(1, 0, 0, 0, 0, 12'h000, 12'h000, 0, 0, 0));
        vecs.push_back(v(0, 1, 0, 0, 0, 12'h0A5, 12'h000, 0, 1, 0));
        vecs.push_back(v(0, 0, 0, 0, 1, 12'h000, 12'h000, 0, 1, 0));
        vecs.push_back(v(0, 1, 0, 0, 0, 12'h000, 12'h000, 0, 1, 0));
        vecs.push_back(v(0, 1, 1, 0, 0, 12'h005, 12'h000, 0, 1, 0));
        vecs.push_back(v(0, 1, 0, 0, 0, 12'h005, 12'h005, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 1, 12'h005, 12'h004, 1, 0, 0));
        vecs.push_back(v(0, 1, 0, 1, 1, 12'h009, 12'h003, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 12'h009, 12'h003, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 1, 12'h000, 12'h002, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 1, 12'h000, 12'h001, 1, 0, 0));
        vecs.push_back(v(0, 0, 1, 0, 1, 12'h000, 12'h000, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 1, 12'h000, 12'h000, 0, 0, 0));
        vecs.push_back(v(0, 1, 0, 1, 1, 12'h003, 12'h003, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 1, 12'h003, 12'h002, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 1, 12'h003, 12'h001, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 1, 12'h003, 12'h003, 1, 0, 1));
        vecs.push_back(v(0, 0, 0, 1, 1, 12'h003, 12'h002, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 1, 12'h003, 12'h001, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 1, 12'h003, 12'h003, 1, 0, 1));
        vecs.push_back(v(1, 0, 0, 1, 1, 12'h003, 12'h000, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 1, 12'h003, 12'h000, 0, 0, 0));
        vecs.push_back(v(0, 1, 0, 1, 1, 12'h001, 12'h001, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 1, 12'h001, 12'h001, 1, 0, 1));
        vecs.push_back(v(0, 0, 0, 1, 1, 12'h001, 12'h001, 1, 0, 1));
        vecs.push_back(v(0, 0, 1, 1, 1, 12'h001, 12'h000, 0, 0, 0));
        vecs.push_back(v(0, 1, 0, 0, 1, 12'h002, 12'h002, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 1, 12'h002, 12'h001, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 1, 12'h002, 12'h000, 0, 0, 1));
        vecs.push_back(v(0, 0, 0, 0, 1, 12'h002, 12'h000, 0, 0, 0));
        vecs.push_back(v(0, 1, 0, 0, 0, 12'hFFF, 12'h000, 0, 1, 0));
        vecs.push_back(v(1, 0, 0, 0, 0, 12'h000, 12'h000, 0, 0, 0));
        vecs.push_back(v(0, 1, 0, 1, 1, 12'h003, 12'h003, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 1, 12'h003, 12'h002, 1, 0, 0));
        vecs.push_back(v(1, 0, 0, 1, 1, 12'h003, 12'h000, 0, 0, 0));
        vecs.push_back(v(0, 1, 0, 1, 1, 12'h002, 12'h002, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 1, 12'h002, 12'h001, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 1, 12'h002, 12'h002, 1, 0, 1));
        vecs.push_back(v(0, 0, 0, 1, 1, 12'h002, 12'h001, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 1, 12'h002, 12'h002, 1, 0, 1));

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].start, vecs[i].stop, vecs[i].mode, vecs[i].en, vecs[i].preset);
            chk($sformatf("vec%0d", i), vecs[i].q, vecs[i].busy, vecs[i].err, vecs[i].pulse);
        end

        // One-shot from 100: digit borrows and a single pulse on the 100th enabled cycle
        step(1, 0, 0, 0, 0, 12'h000);
        step(0, 1, 0, 0, 1, 12'h100);
        chk_model("borrow_start");
        pulses = 0;
        pulse_at = -1;
        for (int i = 1; i <= 102; i++) begin
            step(0, 0, 0, 0, 1, 12'h000);
            chk_model($sformatf("borrow_c%0d", i));
            if (PULSE) begin pulses++; pulse_at = i; end
            if (i == 1)  chk("borrow_099", 12'h099, 1, 0, 0);
            if (i == 91) chk("borrow_009", 12'h009, 1, 0, 0);
        end
        checks++;
        if (pulses != 1 || pulse_at != 100) begin
            failures++;
            $display("FAIL borrow_pulse: got count=%0d at=%0d, expected count=1 at=100", pulses, pulse_at);
        end

        // Continuous 004 with EN toggling; mid-run START and PRESET changes
        step(0, 1, 0, 1, 0, 12'h004);
        pulses = 0;
        for (int i = 0; i < 24; i++) begin
            step(0, (i == 5), 0, $urandom_range(0, 1), (i % 2 == 0), (i > 3) ? 12'h007 : 12'h004);
            chk_model($sformatf("gap_c%0d", i));
            if (PULSE) pulses++;
        end
        checks++;
        if (pulses != 3) begin
            failures++;
            $display("FAIL gap_pulses: got %0d, expected 3", pulses);
        end

        // Random run against the model
        step(1, 0, 0, 0, 0, 12'h000);
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 3) == 0)
                pr = 12'($urandom);
            else
                pr = int2bcd($urandom_range(0, 14));
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 19) == 0), 1'($urandom), ($urandom_range(0, 3) != 0), pr);
            chk_model($sformatf("rand_c%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
